// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one byte-wide FIFO push port among NREQ producers; 0-cycle latency.
// fFull stalls all transfers; optional lock timeout via FIFO_ARB_TIMEOUT_EN.
module fifo_push_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [8*NREQ-1:0] rByte,
  input  logic [NREQ-1:0]   rValid,
  input  logic [NREQ-1:0]   rLast,
  output logic [NREQ-1:0]   rReady,
  output logic [NREQ-1:0]   hGrant,
  output logic [7:0]        fByte,
  output logic              fPush,
  input  logic              fFull,
  output logic              hTimeout
);

  localparam int PTRW = $clog2(NREQ);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state, state_nx;
  logic [PTRW-1:0] ptr, ptr_nx;
  logic [PTRW-1:0] owner, owner_nx;
  logic [PTRW-1:0] cand, scan, gnt;
  logic            cand_vld, gnt_vld, gnt_last;

  // Explicit wrap so non-power-of-2 NREQ never lands on an unused index.
  function automatic logic [PTRW-1:0] next_idx(input logic [PTRW-1:0] idx);
    if (idx == PTRW'(NREQ-1)) return '0;
    return idx + 1'b1;
  endfunction

  always_comb begin
    cand_vld = 1'b0;
    cand     = ptr;
    scan     = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!cand_vld && rValid[scan]) begin
        cand_vld = 1'b1;
        cand     = scan;
      end
      scan = next_idx(scan);
    end
  end

  always_comb begin
    gnt_vld  = (state == LOCKED) || cand_vld;
    gnt      = (state == LOCKED) ? owner : cand;
    gnt_last = rLast[gnt];
    fPush    = gnt_vld && rValid[gnt] && !fFull;
    hGrant   = '0;
    rReady   = '0;
    fByte    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_vld && gnt == PTRW'(i)) begin
        hGrant[i] = 1'b1;
        rReady[i] = fPush;
        fByte     = rByte[8*i +: 8];
      end
    end
  end

`ifdef FIFO_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt, cnt_nx;
  logic          tmo_nx;
`endif

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    owner_nx = owner;
`ifdef FIFO_ARB_TIMEOUT_EN
    cnt_nx   = cnt;
    tmo_nx   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (fPush) begin
          if (gnt_last) begin
            ptr_nx = next_idx(gnt);
          end else begin
            state_nx = LOCKED;
            owner_nx = gnt;
          end
`ifdef FIFO_ARB_TIMEOUT_EN
          cnt_nx = '0;
`endif
        end
      end
      LOCKED: begin
        if (fPush) begin
`ifdef FIFO_ARB_TIMEOUT_EN
          cnt_nx = '0;
`endif
          if (gnt_last) begin
            state_nx = IDLE;
            ptr_nx   = next_idx(owner);
          end
        end
`ifdef FIFO_ARB_TIMEOUT_EN
        // Only a silent owner ages the lock; a full FIFO with data pending does not.
        else if (!rValid[owner]) begin
          if (cnt == CW'(TIMEOUT-1)) begin
            state_nx = IDLE;
            ptr_nx   = next_idx(owner);
            tmo_nx   = 1'b1;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      owner <= owner_nx;
    end
  end

`ifdef FIFO_ARB_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      hTimeout <= 1'b0;
    end else begin
      cnt      <= cnt_nx;
      hTimeout <= tmo_nx;
    end
  end
`else
  assign hTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: directed vector table, reset/timeout sequences, random traffic vs model.
module tb_fifo_push_arbiter;
  localparam int NREQ = 4;
  localparam int TO   = 4;
  localparam logic [31:0] DEF = 32'hD3C2B1A0;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] rByte;
  logic [3:0]  rValid, rLast, rReady, hGrant;
  logic [7:0]  fByte;
  logic        fPush, fFull, hTimeout;

  always #5 clock = ~clock;

  fifo_push_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .rByte(rByte), .rValid(rValid), .rLast(rLast),
    .rReady(rReady), .hGrant(hGrant), .fByte(fByte), .fPush(fPush), .fFull(fFull),
    .hTimeout(hTimeout)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: message-level view of who owns the port and where the search starts.
  bit m_locked;
  int m_owner, m_ptr, m_cnt;
  bit m_tmo;
  int         e_g;
  logic [3:0] e_rdy, e_gnt;
  logic       e_push;
  logic [7:0] e_byte;
  logic [3:0] a_rdy, a_gnt;
  logic       a_push, a_tmo;
  logic [7:0] a_byte;

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic        f;
    logic [31:0] b;
    logic [3:0]  rdy;
    logic [3:0]  gnt;
    logic        push;
    logic [7:0]  byt;
  } vec_t;
  vec_t tbl [15];

  bit         pv [NREQ];
  logic [7:0] pb [NREQ];
  logic       pl [NREQ];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_tmo = 0;
  endtask

  task automatic model_expect();
    e_g = -1;
    if (m_locked) e_g = m_owner;
    else
      for (int k = 0; k < NREQ; k++)
        if (e_g < 0 && rValid[(m_ptr + k) % NREQ]) e_g = (m_ptr + k) % NREQ;
    e_gnt  = (e_g >= 0) ? 4'(1 << e_g) : 4'b0;
    e_push = (e_g >= 0) && rValid[e_g] && !fFull;
    e_rdy  = e_push ? e_gnt : 4'b0;
    e_byte = (e_g >= 0) ? rByte[8*e_g +: 8] : 8'h00;
  endtask

  task automatic model_tick();
    m_tmo = 0;
    if (e_push) begin
      m_cnt = 0;
      if (rLast[e_g]) begin
        m_locked = 0;
        m_ptr    = (e_g + 1) % NREQ;
      end else begin
        m_locked = 1;
        m_owner  = e_g;
      end
    end else if (m_locked && !rValid[m_owner]) begin
`ifdef FIFO_ARB_TIMEOUT_EN
      if (m_cnt == TO - 1) begin
        m_locked = 0;
        m_ptr    = (m_owner + 1) % NREQ;
        m_tmo    = 1;
        m_cnt    = 0;
      end else begin
        m_cnt++;
      end
`endif
    end
  endtask

  task automatic step(input logic [3:0] v, input logic [3:0] l, input logic f, input logic [31:0] b);
    rValid = v; rLast = l; fFull = f; rByte = b;
    @(negedge clock);
    model_expect();
    a_rdy = rReady; a_gnt = hGrant; a_push = fPush; a_byte = fByte; a_tmo = hTimeout;
    chk("rReady", a_rdy, e_rdy);
    chk("hGrant", a_gnt, e_gnt);
    chk("fPush", a_push, e_push);
    if (e_push) chk("fByte", a_byte, e_byte);
    chk("hTimeout", a_tmo, m_tmo);
    @(posedge clock);
    model_tick();
    #1;
  endtask

  initial begin
    tbl[0]  = '{4'b1010, 4'b1111, 1'b0, DEF,          4'b0010, 4'b0010, 1'b1, 8'hB1};
    tbl[1]  = '{4'b1010, 4'b1111, 1'b0, DEF,          4'b1000, 4'b1000, 1'b1, 8'hD3};
    tbl[2]  = '{4'b1010, 4'b1111, 1'b0, DEF,          4'b0010, 4'b0010, 1'b1, 8'hB1};
    tbl[3]  = '{4'b0001, 4'b0000, 1'b0, 32'hD3C2B141, 4'b0001, 4'b0001, 1'b1, 8'h41};
    tbl[4]  = '{4'b0101, 4'b0000, 1'b0, 32'hD3C2B142, 4'b0001, 4'b0001, 1'b1, 8'h42};
    tbl[5]  = '{4'b0101, 4'b0001, 1'b0, 32'hD3C2B143, 4'b0001, 4'b0001, 1'b1, 8'h43};
    tbl[6]  = '{4'b0100, 4'b1111, 1'b0, DEF,          4'b0100, 4'b0100, 1'b1, 8'hC2};
    tbl[7]  = '{4'b1111, 4'b1111, 1'b1, DEF,          4'b0000, 4'b1000, 1'b0, 8'hD3};
    tbl[8]  = '{4'b1111, 4'b1111, 1'b1, DEF,          4'b0000, 4'b1000, 1'b0, 8'hD3};
    tbl[9]  = '{4'b1111, 4'b1111, 1'b1, DEF,          4'b0000, 4'b1000, 1'b0, 8'hD3};
    tbl[10] = '{4'b1111, 4'b1111, 1'b1, DEF,          4'b0000, 4'b1000, 1'b0, 8'hD3};
    tbl[11] = '{4'b1111, 4'b1111, 1'b1, DEF,          4'b0000, 4'b1000, 1'b0, 8'hD3};
    tbl[12] = '{4'b1111, 4'b1111, 1'b0, DEF,          4'b1000, 4'b1000, 1'b1, 8'hD3};
    tbl[13] = '{4'b1111, 4'b1111, 1'b0, DEF,          4'b0001, 4'b0001, 1'b1, 8'hA0};
    tbl[14] = '{4'b0000, 4'b0000, 1'b0, DEF,          4'b0000, 4'b0000, 1'b0, 8'h00};

    reset = 1'b1; rValid = '0; rLast = '0; fFull = 1'b0; rByte = '0;
    model_reset();
    #2;
    chk("rst_fPush", fPush, 1'b0);
    chk("rst_rReady", rReady, 4'b0);
    chk("rst_hGrant", hGrant, 4'b0);
    chk("rst_fByte", fByte, 8'h00);
    chk("rst_hTimeout", hTimeout, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].v, tbl[i].l, tbl[i].f, tbl[i].b);
      chk($sformatf("tbl%0d_rReady", i), a_rdy, tbl[i].rdy);
      chk($sformatf("tbl%0d_hGrant", i), a_gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_fPush", i), a_push, tbl[i].push);
      chk($sformatf("tbl%0d_fByte", i), a_byte, tbl[i].byt);
    end

    // Reset in the middle of a message owned by requester 2.
    step(4'b0100, 4'b0000, 1'b0, DEF);
    step(4'b1111, 4'b0000, 1'b0, DEF);
    chk("lock_hold_owner2", a_gnt, 4'b0100);
    rValid = 4'b1111; rLast = 4'b0000;
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midmsg_rst_grant", hGrant, 4'b0001);
    chk("midmsg_rst_tmo", hTimeout, 1'b0);
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    step(4'b1111, 4'b1111, 1'b0, DEF);
    chk("post_rst_req0", a_rdy, 4'b0001);

    // Owner 1 goes silent after a non-last byte while requester 2 waits.
    step(4'b0010, 4'b0000, 1'b0, DEF);
    chk("lock_owner1", a_rdy, 4'b0010);
    for (int s = 1; s <= 5; s++) begin
      step(4'b0100, 4'b1111, 1'b0, DEF);
`ifdef FIFO_ARB_TIMEOUT_EN
      if (s == 4) chk("tmo_not_early", a_tmo, 1'b0);
      if (s == 5) begin
        chk("tmo_pulse", a_tmo, 1'b1);
        chk("tmo_regrant_req2", a_rdy, 4'b0100);
      end
`else
      if (s == 5) begin
        chk("lock_held_grant", a_gnt, 4'b0010);
        chk("lock_held_nopush", a_push, 1'b0);
      end
`endif
    end
    step(4'b0010, 4'b0010, 1'b0, DEF);

    for (int i = 0; i < NREQ; i++) begin
      pv[i] = 0; pb[i] = '0; pl[i] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      logic [3:0]  v, l;
      logic [31:0] b;
      for (int i = 0; i < NREQ; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1;
          pb[i] = 8'($urandom_range(0, 255));
          pl[i] = ($urandom_range(0, 3) != 0);
        end
        v[i] = pv[i];
        l[i] = pl[i];
        b[8*i +: 8] = pb[i];
      end
      step(v, l, ($urandom_range(0, 3) == 0), b);
      for (int i = 0; i < NREQ; i++)
        if (e_rdy[i]) pv[i] = 0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
